// File: rtl/atomic_counter_reader.sv
// Initiator for a 64-bit atomic counter: atomic low-word read, then high word.
// Define ATOMIC_READER_MONO_CHECK_EN to add the sticky mono_err_o regression flag.
module atomic_counter_reader #(
  parameter int TIMEOUT_CYCLES = 15
) (
`ifdef ATOMIC_READER_MONO_CHECK_EN
  output logic        mono_err_o,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_start_i,
  output logic        rd_busy_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [63:0] rd_value_o,
  output logic        err_o,
  output logic        req_o,
  output logic        atomic_o,
  input  logic        ack_i,
  input  logic [31:0] count_i
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    DONE
  } state_t;

  state_t            state_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [63:0]       value_q;
  logic              req_q;
  logic              atomic_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;
`ifdef ATOMIC_READER_MONO_CHECK_EN
  logic [63:0]       last_q;
  logic              mono_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      value_q  <= '0;
      req_q    <= 1'b0;
      atomic_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ATOMIC_READER_MONO_CHECK_EN
      last_q   <= '0;
      mono_q   <= 1'b0;
`endif
    end else begin
      req_q    <= 1'b0;
      atomic_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rd_start_i) begin
            state_q  <= REQ_LO;
            req_q    <= 1'b1;
            atomic_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        REQ_LO: begin
          state_q <= WAIT_LO;
          tcnt_q  <= '0;
        end
        WAIT_LO: begin
          // ack beats a timeout landing on the same edge
          if (ack_i) begin
            value_q[31:0] <= count_i;
            state_q       <= REQ_HI;
            req_q         <= 1'b1;
          end else if (tcnt_q == TLAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        REQ_HI: begin
          state_q <= WAIT_HI;
          tcnt_q  <= '0;
        end
        WAIT_HI: begin
          if (ack_i) begin
            value_q[63:32] <= count_i;
            state_q        <= DONE;
            valid_q        <= 1'b1;
`ifdef ATOMIC_READER_MONO_CHECK_EN
            if ({count_i, value_q[31:0]} < last_q)
              mono_q <= 1'b1;
`endif
          end else if (tcnt_q == TLAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        DONE: begin
          if (rd_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ATOMIC_READER_MONO_CHECK_EN
            last_q  <= value_q;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_busy_o  = busy_q;
  assign rd_valid_o = valid_q;
  assign rd_value_o = value_q;
  assign err_o      = err_q;
  assign req_o      = req_q;
  assign atomic_o   = atomic_q;
`ifdef ATOMIC_READER_MONO_CHECK_EN
  assign mono_err_o = mono_q;
`endif

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Bench for atomic_counter_reader: behavioural counter/responder model,
// scoreboard of expected 64-bit snapshots and directed corner cases.
module tb_atomic_counter_reader;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_start_i = 1'b0;
  logic        rd_ready_i = 1'b0;
  logic        ack_i = 1'b0;
  logic [31:0] count_i = '0;
  logic        rd_busy_o;
  logic        rd_valid_o;
  logic [63:0] rd_value_o;
  logic        err_o;
  logic        req_o;
  logic        atomic_o;
`ifdef ATOMIC_READER_MONO_CHECK_EN
  logic        mono_err_o;
`endif

  atomic_counter_reader #(.TIMEOUT_CYCLES(TO)) dut (
`ifdef ATOMIC_READER_MONO_CHECK_EN
    .mono_err_o (mono_err_o),
`endif
    .clk        (clk),
    .reset      (reset),
    .rd_start_i (rd_start_i),
    .rd_busy_o  (rd_busy_o),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_value_o (rd_value_o),
    .err_o      (err_o),
    .req_o      (req_o),
    .atomic_o   (atomic_o),
    .ack_i      (ack_i),
    .count_i    (count_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // responder / counter model controls (written by the directed branch)
  logic [63:0] cnt_base = '0;
  int          gen = 0;
  int          trig_mode = 0;
  int          lo_force = 1;
  int          hi_force = 1;
  bit          stray_en = 1'b0;

  // responder / monitor state
  logic [63:0] cnt_inc = '0;
  int          seen_gen = 0;
  bit          pend = 1'b0;
  int          wait_n = 0;
  int          dhi = 0;
  logic [31:0] pdata = '0;
  logic [63:0] snap = '0;
  bit          prev_req = 1'b0;
  bit          hold_v = 1'b0;
  logic [63:0] hold_val = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ack delay in cycles after the request cycle; 0 means never acknowledge
  function automatic int pick_d();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 4) return 1;
    if (r == 5) return 2;
    if (r == 6) return 3;
    if (r == 7) return TO;
    if (r == 8) return TO - 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mon_step();
    exp_t        e;
    logic [63:0] cnt;
    int          dlo;
    if (reset) begin
      pend     = 1'b0;
      ack_i    = 1'b0;
      prev_req = 1'b0;
      hold_v   = 1'b0;
      sb_q.delete();
      return;
    end
    if (req_o)
      chk("req_single_pulse", 64'(prev_req), 64'd0);
    if (hold_v && rd_valid_o)
      chk("value_hold", rd_value_o, hold_val);
    if (rd_valid_o && rd_ready_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        chk("result_not_error", 64'(e.err), 64'd0);
        chk("result_value", rd_value_o, e.val);
      end
    end
    if (err_o) begin
      chk("err_with_valid", 64'(rd_valid_o), 64'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_err", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        chk("err_expected", 64'(e.err), 64'd1);
      end
    end
    hold_v   = rd_valid_o && !rd_ready_i;
    hold_val = rd_value_o;
    prev_req = req_o;

    if (gen != seen_gen) begin
      seen_gen = gen;
      cnt_inc  = '0;
    end
    cnt = cnt_base + cnt_inc;

    ack_i   = 1'b0;
    count_i = $urandom();
    if (pend) begin
      if (err_o) begin
        pend = 1'b0;
      end else if (wait_n > 0) begin
        wait_n--;
        if (wait_n == 0) begin
          ack_i   = 1'b1;
          count_i = pdata;
          pend    = 1'b0;
        end
      end
    end
    if (req_o) begin
      if (atomic_o) begin
        snap = cnt;
        dlo  = (lo_force < 0) ? pick_d() : lo_force;
        dhi  = (hi_force < 0) ? pick_d() : hi_force;
        sb_q.push_back('{err: (dlo == 0 || dhi == 0), val: snap});
        pdata  = snap[31:0];
        wait_n = dlo;
      end else begin
        pdata  = snap[63:32];
        wait_n = dhi;
      end
      pend = 1'b1;
    end else if (!pend && stray_en && $urandom_range(0, 7) == 0) begin
      ack_i = 1'b1;
    end

    if (trig_mode == 1 || (trig_mode == 2 && $urandom_range(0, 1) == 1))
      cnt_inc = cnt_inc + 64'd1;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 40 && !rd_valid_o; k++)
      tick();
    chk(name, 64'(rd_valid_o), 64'd1);
  endtask

  task automatic start_pulse();
    rd_start_i = 1'b1;
    tick();
    rd_start_i = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
      begin : directed
        logic [63:0] v;
        int          first;
        int          npulses;

        #1 reset = 1'b1;
        #2;
        chk("rst_busy", 64'(rd_busy_o), 64'd0);
        chk("rst_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_req", 64'(req_o), 64'd0);
        chk("rst_atomic", 64'(atomic_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_value", rd_value_o, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // cycle-exact zero-wait read
        gen++;
        cnt_base   = 64'h0000_0001_FFFF_FFFE;
        trig_mode  = 0;
        lo_force   = 1;
        hi_force   = 1;
        rd_ready_i = 1'b1;
        start_pulse();
        chk("c1_req", 64'(req_o), 64'd1);
        chk("c1_atomic", 64'(atomic_o), 64'd1);
        chk("c1_busy", 64'(rd_busy_o), 64'd1);
        tick();
        chk("c2_req", 64'(req_o), 64'd0);
        tick();
        chk("c3_req", 64'(req_o), 64'd1);
        chk("c3_atomic", 64'(atomic_o), 64'd0);
        tick();
        chk("c4_valid", 64'(rd_valid_o), 64'd0);
        tick();
        chk("c5_valid", 64'(rd_valid_o), 64'd1);
        chk("c5_value", rd_value_o, 64'h0000_0001_FFFF_FFFE);
        tick();
        chk("c6_valid", 64'(rd_valid_o), 64'd0);
        chk("c6_busy", 64'(rd_busy_o), 64'd0);

        // counter ticking across the 32-bit carry during the read
        gen++;
        cnt_base  = 64'h0000_0000_FFFF_FFFF;
        trig_mode = 1;
        tick();
        start_pulse();
        wait_valid("carry_valid");
        v = rd_value_o;
        chk("carry_not_torn",
            64'(v >= 64'h0000_0000_FFFF_FFFF && v <= 64'h0000_0001_0000_0003),
            64'd1);
        tick();
        trig_mode = 0;

        // consumer stalls in DONE; starts there are ignored
        rd_ready_i = 1'b0;
        start_pulse();
        wait_valid("stall_valid");
        v = rd_value_o;
        for (int i = 0; i < 10; i++) begin
          rd_start_i = i[0];
          tick();
          chk("stall_valid_hold", 64'(rd_valid_o), 64'd1);
          chk("stall_value_hold", rd_value_o, v);
          chk("stall_no_req", 64'(req_o), 64'd0);
        end
        rd_start_i = 1'b0;
        rd_ready_i = 1'b1;
        tick();
        chk("stall_release_valid", 64'(rd_valid_o), 64'd0);
        chk("stall_release_busy", 64'(rd_busy_o), 64'd0);

        // no ack on the low word
        lo_force = 0;
        start_pulse();
        first   = -1;
        npulses = 0;
        for (int k = 2; k <= 12; k++) begin
          tick();
          if (err_o) begin
            npulses++;
            if (first < 0) first = k;
          end
          chk("to_no_valid", 64'(rd_valid_o), 64'd0);
        end
        chk("to_pulse_count", 64'(npulses), 64'd1);
        chk("to_pulse_cycle", 64'(first), 64'(2 + TO));
        chk("to_busy_after", 64'(rd_busy_o), 64'd0);

        // ack on the last allowed wait cycle still wins
        gen++;
        cnt_base = 64'hDEAD_BEEF_0123_4567;
        lo_force = TO;
        hi_force = TO;
        tick();
        start_pulse();
        wait_valid("late_ack_valid");
        chk("late_ack_value", rd_value_o, 64'hDEAD_BEEF_0123_4567);
        tick();

        // reset while waiting on the high word
        lo_force = 1;
        hi_force = 0;
        start_pulse();
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 64'(rd_busy_o), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(rd_busy_o), 64'd0);
        chk("mid_rst_req", 64'(req_o), 64'd0);
        chk("mid_rst_valid", 64'(rd_valid_o), 64'd0);
        chk("mid_rst_err", 64'(err_o), 64'd0);
        chk("mid_rst_value", rd_value_o, 64'd0);
        tick();
        tick();
        reset    = 1'b0;
        hi_force = 1;
        for (int k = 0; k < 6; k++) begin
          tick();
          chk("post_rst_no_req", 64'(req_o), 64'd0);
          chk("post_rst_idle", 64'(rd_busy_o), 64'd0);
        end

`ifdef ATOMIC_READER_MONO_CHECK_EN
        gen++;
        cnt_base = 64'h10;
        tick();
        start_pulse();
        wait_valid("mono1_valid");
        chk("mono1_flag", 64'(mono_err_o), 64'd0);
        tick();
        gen++;
        cnt_base = 64'h5;
        tick();
        start_pulse();
        wait_valid("mono2_valid");
        chk("mono2_flag", 64'(mono_err_o), 64'd1);
        tick();
        tick();
        tick();
        chk("mono_sticky", 64'(mono_err_o), 64'd1);
`endif

        // randomized traffic against the scoreboard
        gen++;
        cnt_base  = 64'h0000_0000_FFFF_FF00;
        trig_mode = 2;
        lo_force  = -1;
        hi_force  = -1;
        stray_en  = 1'b1;
        tick();
        for (int i = 0; i < 3000; i++) begin
          rd_start_i = ($urandom_range(0, 3) == 0);
          rd_ready_i = ($urandom_range(0, 2) != 0);
          tick();
        end
        rd_start_i = 1'b0;
        rd_ready_i = 1'b1;
        stray_en   = 1'b0;
        for (int k = 0; k < 100 && (rd_busy_o || rd_valid_o); k++)
          tick();
        tick();
        tick();
        chk("drain_idle", 64'(rd_busy_o), 64'd0);
        chk("drain_scoreboard", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end

endmodule
